// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: instruction-in / immediate-out bus of the immediate
// generator stage.
//   in_valid, in_instr, in_tag  : producer -> stage
//   in_ready                    : stage -> producer
//   out_valid, out_imm, out_fmt, out_illegal, out_tag : stage -> consumer
//   out_ready                   : consumer -> stage
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high. Once valid is raised, the sender keeps valid and its
// payload steady until that transfer. Ready may change freely and never
// depends combinationally on valid.
// Modports: master = the surrounding pipeline, slave = the stage.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate generator with a two-entry
// skid buffer (output register + skid register).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (beats flush and handshakes)
//   flush  : synchronous discard of every buffered entry and the input beat
//   bus    : imm_gen_stage_if.slave (instruction in, immediate/format/
//            illegal/tag out)
// Format codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
module imm_gen_stage #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 8,
    parameter int CSR_ZIMM = 1
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    imm_gen_stage_if.slave  bus
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // ---------------------------------------------------------------
    // Decode (combinational on the incoming instruction)
    // ---------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];

    // Immediate fields as signed values; a size cast to XLEN then
    // sign-extends them, which also covers the XLEN=64 upper half.
    logic signed [11:0] imm_i_s;
    logic signed [11:0] imm_s_s;
    logic signed [12:0] imm_b_s;
    logic signed [31:0] imm_u_s;
    logic signed [20:0] imm_j_s;

    assign imm_i_s = instr[31:20];
    assign imm_s_s = {instr[31:25], instr[11:7]};
    assign imm_b_s = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s = {instr[31:12], 12'b0};
    assign imm_j_s = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    entry_t dec;

    always_comb begin
        dec.imm     = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        dec.tag     = bus.in_tag;
        unique case (opcode)
            // OP-IMM, LOAD, JALR, MISC-MEM, OP-IMM-32
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b0011011: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'(imm_i_s);
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'(imm_s_s);
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'(imm_b_s);
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'(imm_u_s);
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'(imm_j_s);
            end
            7'b1110011: begin
                // funct3[2] selects the immediate CSR forms (csrr*i)
                if (CSR_ZIMM != 0 && instr[14]) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(instr[19:15]);
                end
            end
            7'b0110011, 7'b0111011: begin
                // R-type: legal, no immediate
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // Skid buffer
    // ---------------------------------------------------------------
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;

    logic accept;
    logic consume;

    // in_ready is the registered "skid empty" flag, so it has no
    // combinational path from out_ready.
    assign accept  = bus.in_valid & ~skid_valid_q;
    assign consume = out_valid_q & bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            // Payload registers keep their contents; only valids drop.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // accept implies the skid is empty, so this never collides
            // with the skid-to-output move above.
            if (accept) begin
                if (!out_valid_q || consume) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready    = ~skid_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_tag     = out_q.tag;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: drives an XLEN=32 and an XLEN=64 instance of
// imm_gen_stage with identical stimulus and checks both against a
// queue-based reference of a two-deep FIFO and an arithmetic immediate
// decoder.
module tb_imm_gen_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic in_valid;
    logic out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(8)) bus32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32), .TAG_W(8), .CSR_ZIMM(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave)
    );
    imm_gen_stage #(.XLEN(64), .TAG_W(8), .CSR_ZIMM(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave)
    );

    // Entry layout: [75:68] tag, [67] illegal, [66:64] fmt, [63:0] imm
    logic [75:0] obs64;
    logic [43:0] obs32;
    assign obs64 = {bus64.out_tag, bus64.out_illegal, bus64.out_fmt, bus64.out_imm};
    assign obs32 = {bus32.out_tag, bus32.out_illegal, bus32.out_fmt, bus32.out_imm};

    int vectors;
    int miscompares;
    logic [75:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [63:0] sext(logic [63:0] v, int bits);
        logic [63:0] one;
        one = 64'd1;
        if (v[bits-1]) return v - (one << bits);
        return v;
    endfunction

    function automatic logic [75:0] ref_entry(logic [31:0] ins, logic [7:0] tag);
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        imm = 64'd0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B: begin
                fmt = 3'd1; imm = sext(64'(ins[31:20]), 12);
            end
            7'h23: begin
                fmt = 3'd2; imm = sext(64'({ins[31:25], ins[11:7]}), 12);
            end
            7'h63: begin
                fmt = 3'd3;
                imm = sext(64'(ins[31]) * 4096 + 64'(ins[7]) * 2048
                           + 64'(ins[30:25]) * 32 + 64'(ins[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin
                fmt = 3'd4; imm = sext(64'(ins[31:12]) * 4096, 32);
            end
            7'h6F: begin
                fmt = 3'd5;
                imm = sext(64'(ins[31]) * (64'd1 << 20) + 64'(ins[19:12]) * 4096
                           + 64'(ins[20]) * 2048 + 64'(ins[30:21]) * 2, 21);
            end
            7'h73: begin
                if (ins[14]) begin
                    fmt = 3'd6; imm = 64'(ins[19:15]);
                end
            end
            7'h33, 7'h3B: ;
            default: ill = 1'b1;
        endcase
        return {tag, ill, fmt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[16];
        logic [6:0] op;
        int k;
        ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h73, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h00};
        k = $urandom_range(0, 16);
        op = (k == 16) ? 7'($urandom) : ops[k];
        return {25'($urandom), op};
    endfunction

    // Advance one clock: update the FIFO model from the inputs currently
    // driven, then wait for the edge and settle.
    task automatic tick();
        bit can_take;
        can_take = exp_q.size() < 2;
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && can_take) exp_q.push_back(ref_entry(in_instr, in_tag));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'h55;
        tick();
        tick();
        vectors++;
        if (bus64.out_valid !== 1'b0 || bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b/%b expected 0", bus32.out_valid, bus64.out_valid);
        end
        vectors++;
        if (bus64.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b/%b expected 1", bus32.in_ready, bus64.in_ready);
        end
        vectors++;
        if (obs64 !== 76'd0 || obs32 !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_payload: got %h/%h expected 0", obs32, obs64);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] t_ins[9];
        logic [63:0] t_imm[9];
        logic [2:0]  t_fmt[9];
        logic        t_ill[9];
        logic [75:0] e64;
        t_ins = '{32'hFFF00093, 32'h00512423, 32'hFFDFF06F, 32'h800000B7, 32'h3002D073,
                  32'hFE000EE3, 32'h0000007F, 32'h00000033, 32'h3002A073};
        t_imm = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                  64'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h0};
        t_fmt = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd6, 3'd3, 3'd0, 3'd0, 3'd0};
        t_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1; in_instr = t_ins[k]; in_tag = 8'(k + 1);
            tick();
            e64 = {8'(k + 1), t_ill[k], t_fmt[k], t_imm[k]};
            vectors++;
            if (bus64.out_valid !== 1'b1 || obs64 !== e64) begin
                miscompares++;
                $display("FAIL directed64[%0d]: got v=%b %h expected v=1 %h", k, bus64.out_valid, obs64, e64);
            end
            vectors++;
            if (bus32.out_valid !== 1'b1 || obs32 !== {e64[75:64], e64[31:0]}) begin
                miscompares++;
                $display("FAIL directed32[%0d]: got v=%b %h expected v=1 %h", k, bus32.out_valid, obs32, {e64[75:64], e64[31:0]});
            end
            vectors++;
            if (bus64.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_ready[%0d]: got %b/%b expected 1", k, bus32.in_ready, bus64.in_ready);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (bus64.out_valid !== 1'b0 || bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL directed_drain: got %b/%b expected 0", bus32.out_valid, bus64.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  got[$];
        logic [75:0] held;
        bit          taken;
        out_ready = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_tag = 8'(t);
            tick();
        end
        vectors++;
        if (bus64.in_ready !== 1'b0 || bus32.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_drop: got %b/%b expected 0", bus32.in_ready, bus64.in_ready);
        end
        held = obs64;
        in_instr = rand_instr(); in_tag = 8'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (bus64.out_valid !== 1'b1 || obs64 !== held || bus64.out_tag !== 8'd1 || bus64.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: got v=%b rdy=%b %h expected v=1 rdy=0 %h tag 01", c, bus64.out_valid, bus64.in_ready, obs64, held);
            end
        end
        out_ready = 1'b1;
        taken = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus64.out_valid) got.push_back(bus64.out_tag);
            if (in_valid && bus64.in_ready) taken = 1'b1;
            tick();
            if (taken) in_valid = 1'b0;
            vectors++;
            if (exp_q.size() > 0 && (obs64 !== exp_q[0] || obs32 !== {exp_q[0][75:64], exp_q[0][31:0]})) begin
                miscompares++;
                $display("FAIL bp_drain_payload[%0d]: got %h expected %h", c, obs64, exp_q[0]);
            end
        end
        vectors++;
        if (got.size() != 3 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3) begin
            miscompares++;
            $display("FAIL bp_order: got %0d tags %p expected 1,2,3", got.size(), got);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_tag = 8'(10 + t);
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_instr = rand_instr(); in_tag = 8'd12;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (bus64.out_valid !== 1'b0 || bus32.out_valid !== 1'b0 ||
            bus64.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_next: got v=%b/%b rdy=%b/%b expected v=0 rdy=1",
                     bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (bus64.out_valid !== 1'b0 || bus32.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_ghost[%0d]: got %b/%b expected 0", c, bus32.out_valid, bus64.out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [75:0] e64;
        out_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_tag = 8'(20 + t);
            tick();
        end
        rst_n = 1'b0; in_tag = 8'd22; in_instr = rand_instr();
        tick();
        vectors++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || obs64 !== 76'd0 ||
            bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || obs32 !== 44'd0) begin
            miscompares++;
            $display("FAIL midreset: got v=%b rdy=%b %h expected v=0 rdy=1 0", bus64.out_valid, bus64.in_ready, obs64);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_tag = 8'(30 + t);
            e64 = ref_entry(in_instr, in_tag);
            tick();
            vectors++;
            if (bus64.out_valid !== 1'b1 || obs64 !== e64 || obs32 !== {e64[75:64], e64[31:0]}) begin
                miscompares++;
                $display("FAIL restart[%0d]: got v=%b %h expected v=1 %h", t, bus64.out_valid, obs64, e64);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        bit exp_ready;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = rand_instr();
            in_tag    = 8'($urandom);
            tick();
            exp_ready = exp_q.size() < 2;
            vectors++;
            if (bus64.in_ready !== exp_ready || bus32.in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got %b/%b expected %b", c, bus32.in_ready, bus64.in_ready, exp_ready);
            end
            vectors++;
            if (bus64.out_valid !== (exp_q.size() > 0) || bus32.out_valid !== (exp_q.size() > 0)) begin
                miscompares++;
                $display("FAIL rand_valid[%0d]: got %b/%b expected %b", c, bus32.out_valid, bus64.out_valid, exp_q.size() > 0);
            end
            if (exp_q.size() > 0) begin
                vectors++;
                if (obs64 !== exp_q[0] || obs32 !== {exp_q[0][75:64], exp_q[0][31:0]}) begin
                    miscompares++;
                    $display("FAIL rand_payload[%0d]: got %h / %h expected %h", c, obs32, obs64, exp_q[0]);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_tag = 8'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
